// File: rtl/mem_readback_seq.sv
// Walks result-memory addresses 0..last, captures each returned word and streams it out with its address.
// Optional READBACK_CHECKSUM_EN adds a running modulo-2^DATA_W sum of accepted words.
module mem_readback_seq #(
    parameter int DATA_W     = 29,
    parameter int ADDR_W     = 5,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] maxfilled_addr,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef READBACK_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t                       state;
    logic [ADDR_W-1:0]            last;
    logic [ADDR_W:0]              next_addr;
    logic [RD_LAT:1]              vld_q;
    logic [RD_LAT:1][ADDR_W-1:0]  tag_q;
    logic [RD_LAT:0]              vld_pipe;
    logic [RD_LAT:0][ADDR_W-1:0]  tag_pipe;
    entry_t                       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr, rd_ptr;
    logic [CNT_W-1:0]             fifo_count, inflight;
    logic [CNT_W:0]               credit_used;
    logic                         issue, push, pop;

    // Stage 0 is the read currently presented to the memory; the last stage lines up with mem_rd_data.
    assign vld_pipe = {vld_q, mem_rd_en};
    assign tag_pipe = {tag_q, mem_rd_addr};

    assign push        = vld_pipe[RD_LAT];
    assign pop         = out_valid && out_ready;
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign issue       = (state == ISSUE) && (credit_used < (CNT_W+1)'(FIFO_DEPTH));

    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr].data : '0;
    assign out_addr  = out_valid ? fifo_mem[rd_ptr].addr : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            for (int i = 1; i <= RD_LAT; i++) begin
                vld_q[i] <= vld_pipe[i-1];
                tag_q[i] <= tag_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{addr: tag_pipe[RD_LAT], data: mem_rd_data};
    end

    // Inflight covers every issued read not yet pushed, so fifo_count + inflight never exceeds FIFO_DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            inflight   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            case ({issue, push})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last        <= '0;
            next_addr   <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        last      <= maxfilled_addr;
                        next_addr <= '0;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= next_addr[ADDR_W-1:0];
                        next_addr   <= next_addr + (ADDR_W+1)'(1);
                        if (next_addr == {1'b0, last}) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (inflight == '0 && fifo_count == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef READBACK_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       checksum <= '0;
        else if (state == IDLE && start) checksum <= '0;
        else if (pop)                   checksum <= checksum + out_data;
    end
`endif

endmodule
